// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC trigger/capture slice.
// Sample width, capture FSM states and the ADC mid-scale code.
package adc_pkg;

  localparam int ADC_W = 12;

  localparam logic [ADC_W-1:0] ADC_MID = 12'd2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } state_t;

endpackage

// File: rtl/adc_trigger_capture_if.sv
// Readout stream of the capture buffer: valid/ready with last marker.
// The capture block is master, the host bridge is slave.
interface adc_trigger_capture_if;
  import adc_pkg::*;

  logic             rd_valid;
  logic             rd_ready;
  logic [ADC_W-1:0] rd_data;
  logic             rd_last;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The read register only loads on re, so it doubles as the output stage.
module capture_ram #(
  parameter int AW = 10,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
    end else if (re) begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// Triggered capture of the ADC sample stream into a circular buffer,
// then oldest-first readout of the frozen window.
module adc_trigger_capture
  import adc_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int PRE_TRIG   = 256
) (
  input  logic             clk_400M,
  input  logic             rst,
  input  logic [ADC_W-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             arm,
  input  logic [ADC_W-1:0] trig_level,
  input  logic             trig_falling,
  input  logic             force_trig,
  output logic             busy,
  output logic             triggered,
  output logic             capture_done,
  adc_trigger_capture_if.master rd
);

  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  if (PRE_TRIG < 1 || PRE_TRIG > DEPTH - 1) begin : g_bad_pre
    $error("PRE_TRIG out of range");
  end

  localparam logic [AW:0]   FILL_END = (AW+1)'(PRE_TRIG - 1);
  localparam logic [AW:0]   POST_END = (AW+1)'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW:0]   RD_END   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   RD_LAST  = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFS  = AW'(PRE_TRIG);

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    trig_addr;
  logic [AW-1:0]    ra;
  logic [AW:0]      cnt;
  logic [AW:0]      rd_cnt;
  logic [ADC_W-1:0] prev;
  logic [ADC_W-1:0] level;
  logic             falling;
  logic             force_seen;
  logic             cap;
  logic             we;
  logic             edge_hit;
  logic             hit;
  logic             re;
  logic             rd_fire;

  assign busy         = state != ST_IDLE;
  assign triggered    = state == ST_POST || state == ST_DONE;
  assign capture_done = state == ST_DONE;

  assign cap = state == ST_FILL || state == ST_ARMED
            || state == ST_POST;
  assign we  = cap && sample_valid;

  assign edge_hit = falling
    ? (prev >= level && sample_in < level)
    : (prev < level && sample_in >= level);
  assign hit = edge_hit || force_seen || force_trig;

  assign rd_fire = rd.rd_valid && rd.rd_ready;
  // Issue a read whenever the output register is empty or draining.
  assign re = state == ST_DONE && rd_cnt != RD_END
           && (!rd.rd_valid || rd.rd_ready);
  assign ra = trig_addr - PRE_OFS + rd_cnt[AW-1:0];

  always_ff @(posedge clk_400M) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      trig_addr  <= '0;
      cnt        <= '0;
      prev       <= '0;
      level      <= ADC_MID;
      falling    <= 1'b0;
      force_seen <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + AW'(1);
        prev   <= sample_in;
      end
      unique case (state)
        ST_IDLE: begin
          if (arm) begin
            level      <= trig_level;
            falling    <= trig_falling;
            wr_ptr     <= '0;
            cnt        <= '0;
            force_seen <= 1'b0;
            state      <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (sample_valid) begin
            cnt <= cnt + (AW+1)'(1);
            if (cnt == FILL_END) begin
              state <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (force_trig) begin
            force_seen <= 1'b1;
          end
          if (sample_valid && hit) begin
            trig_addr <= wr_ptr;
            cnt       <= (AW+1)'(1);
            state     <= (POST_END == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (sample_valid) begin
            cnt <= cnt + (AW+1)'(1);
            if (cnt == POST_END) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (rd_fire && rd.rd_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_400M) begin
    if (rst) begin
      rd_cnt      <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_last  <= 1'b0;
    end else begin
      if (re) begin
        rd_cnt      <= rd_cnt + (AW+1)'(1);
        rd.rd_valid <= 1'b1;
        rd.rd_last  <= rd_cnt == RD_LAST;
      end else if (rd_fire) begin
        rd.rd_valid <= 1'b0;
        rd.rd_last  <= 1'b0;
      end
      if (state != ST_DONE) begin
        rd_cnt <= '0;
      end
    end
  end

  capture_ram #(
    .AW (AW),
    .DW (ADC_W)
  ) u_ram (
    .clk (clk_400M),
    .rst (rst),
    .we  (we),
    .wa  (wr_ptr),
    .wd  (sample_in),
    .re  (re),
    .ra  (ra),
    .rd  (rd.rd_data)
  );

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed bench for adc_trigger_capture with DEPTH=16, PRE_TRIG=4.
// Expected windows are written out by hand from the stimulus.
module tb_adc_trigger_capture;
  import adc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        arm = 1'b0;
  logic [11:0] trig_level = ADC_MID;
  logic        trig_falling = 1'b0;
  logic        force_trig = 1'b0;
  logic        busy;
  logic        triggered;
  logic        capture_done;

  int checks = 0;
  int fails  = 0;
  int exp_w[16];

  always #5 clk = ~clk;

  adc_trigger_capture_if rd_if ();

  adc_trigger_capture #(
    .DEPTH_LOG2 (4),
    .PRE_TRIG   (4)
  ) dut (
    .clk_400M     (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .force_trig   (force_trig),
    .busy         (busy),
    .triggered    (triggered),
    .capture_done (capture_done),
    .rd           (rd_if)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (3) tick();
  endtask

  // Level/polarity inputs are scrambled right after arm to show they were latched.
  task automatic do_arm(input logic [11:0] lvl, input logic fall);
    trig_level   = lvl;
    trig_falling = fall;
    arm          = 1'b1;
    tick();
    arm          = 1'b0;
    trig_level   = ADC_MID;
    trig_falling = ~fall;
  endtask

  task automatic read_window(input string tag, input bit stall,
                             input bit arm_last);
    int idx = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [11:0] held_d = '0;
    logic held_l = 1'b0;
    while (idx < 16 && cyc < 400) begin
      rd_if.rd_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (hold) begin
        chk({tag, " hold_valid"}, rd_if.rd_valid, 1);
        chk({tag, " hold_data"}, rd_if.rd_data, held_d);
        chk({tag, " hold_last"}, rd_if.rd_last, held_l);
      end
      hold   = rd_if.rd_valid && !rd_if.rd_ready;
      held_d = rd_if.rd_data;
      held_l = rd_if.rd_last;
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        chk({tag, " data"}, rd_if.rd_data, exp_w[idx]);
        chk({tag, " last"}, rd_if.rd_last, idx == 15);
        if (idx == 15 && arm_last) begin
          trig_level = 12'd100;
          arm = 1'b1;
        end
        idx++;
      end
      tick();
      arm = 1'b0;
      cyc++;
    end
    rd_if.rd_ready = 1'b0;
    chk({tag, " words"}, idx, 16);
    chk({tag, " valid_off"}, rd_if.rd_valid, 0);
    chk({tag, " idle"}, busy, 0);
  endtask

  task automatic ramp_capture(input string tag);
    do_arm(12'd1000, 1'b0);
    chk({tag, " busy"}, busy, 1);
    chk({tag, " trig0"}, triggered, 0);
    for (int i = 0; i <= 9; i++) send(12'(100 * i));
    chk({tag, " armed_trig"}, triggered, 0);
    trig_level = 12'd50;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 10; i <= 20; i++) send(12'(100 * i));
    chk({tag, " post_trig"}, triggered, 1);
    chk({tag, " post_done"}, capture_done, 0);
    send(12'd2100);
    chk({tag, " done"}, capture_done, 1);
    chk({tag, " done_busy"}, busy, 1);
    chk({tag, " first_valid"}, rd_if.rd_valid, 1);
    chk({tag, " first_data"}, rd_if.rd_data, 600);
    for (int i = 0; i < 16; i++) exp_w[i] = 600 + 100 * i;
  endtask

  int fall_s[16] = '{3000, 2500, 2100, 2049, 2047, 2000, 1900, 1800,
                     1700, 1600, 1500, 1400, 1300, 1200, 1100, 1000};

  initial begin
    rd_if.rd_ready = 1'b0;
    tick();
    tick();
    chk("rst busy", busy, 0);
    chk("rst triggered", triggered, 0);
    chk("rst done", capture_done, 0);
    chk("rst rd_valid", rd_if.rd_valid, 0);
    chk("rst rd_last", rd_if.rd_last, 0);
    chk("rst rd_data", rd_if.rd_data, 0);
    rst = 1'b0;
    tick();

    ramp_capture("rise");
    read_window("rise", 1'b0, 1'b1);

    do_arm(12'd2048, 1'b1);
    for (int i = 0; i < 16; i++) send(12'(fall_s[i]));
    chk("fall done", capture_done, 1);
    exp_w = fall_s;
    read_window("fall", 1'b0, 1'b0);

    do_arm(12'd4000, 1'b0);
    send(12'd500);
    send(12'd501);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    send(12'd502);
    send(12'd503);
    send(12'd504);
    send(12'd505);
    send(12'd506);
    chk("force armed", triggered, 0);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    chk("force pending", triggered, 0);
    send(12'd507);
    chk("force trig", triggered, 1);
    for (int i = 508; i <= 518; i++) send(12'(i));
    chk("force done", capture_done, 1);
    for (int i = 0; i < 16; i++) exp_w[i] = 503 + i;
    read_window("force", 1'b0, 1'b0);

    do_arm(12'd3000, 1'b0);
    for (int i = 0; i < 40; i++) send(12'(10 * i));
    send(12'd3000);
    for (int k = 1; k <= 11; k++) send(12'(3000 + k));
    chk("wrap done", capture_done, 1);
    exp_w[0] = 360;
    exp_w[1] = 370;
    exp_w[2] = 380;
    exp_w[3] = 390;
    for (int k = 0; k < 12; k++) exp_w[4 + k] = 3000 + k;
    read_window("wrap", 1'b1, 1'b0);

    do_arm(12'd1000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sample_in    = 12'(200 * i);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    tick();
    chk("b2b done", capture_done, 1);
    for (int k = 0; k < 16; k++) exp_w[k] = 200 * (k + 1);
    read_window("b2b", 1'b0, 1'b0);

    do_arm(12'd1000, 1'b0);
    for (int i = 0; i <= 11; i++) send(12'(100 * i));
    chk("rstpost trig", triggered, 1);
    rst = 1'b1;
    tick();
    chk("rstpost busy", busy, 0);
    chk("rstpost triggered", triggered, 0);
    chk("rstpost done", capture_done, 0);
    chk("rstpost rd_valid", rd_if.rd_valid, 0);
    chk("rstpost rd_last", rd_if.rd_last, 0);
    chk("rstpost rd_data", rd_if.rd_data, 0);
    rst = 1'b0;
    tick();
    ramp_capture("rearm");
    read_window("rearm", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/adc_trigger_capture.md
# adc_trigger_capture

Triggered sample-capture buffer placed directly downstream of the AD9226 read stage. Consumes the 12-bit sample stream and its read strobe, and keeps a circular history of samples. On a programmable level crossing it freezes a window made of pre-trigger and post-trigger samples. The frozen window is then streamed out oldest-first over a valid/ready port to the host-side logic (UART/FIFO bridge).

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: buffer depth is DEPTH = 2^DEPTH_LOG2 samples.
- `PRE_TRIG`, default 256: number of samples kept before the trigger sample. Legal range is 1 ≤ PRE_TRIG ≤ DEPTH-1; elaboration error outside it.

Ports:
- `clk_400M` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sample_in` in 12: unsigned ADC code (0..4095).
- `sample_valid` in 1: one-cycle strobe qualifying `sample_in`; nominally 1 in 4 cycles, but back-to-back strobes must be accepted.
- `arm` in 1: pulse that starts a capture; honoured only in IDLE.
- `trig_level` in 12: trigger threshold; sampled when `arm` is accepted.
- `trig_falling` in 1: 0 selects rising-edge trigger, 1 selects falling-edge; sampled when `arm` is accepted.
- `force_trig` in 1: forces a trigger on the next valid sample while in ARMED.
- `busy` out 1: high in every state except IDLE.
- `triggered` out 1: high in POST and DONE.
- `capture_done` out 1: high in DONE.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out 12, `rd_last` out 1: readout stream.

## Operation
- States: IDLE → FILL → ARMED → POST → DONE → IDLE.
- IDLE: `arm` latches `trig_level` and `trig_falling`, clears write pointer `wr_ptr` and the pre-trigger count, then moves to FILL.
- Writes: in FILL, ARMED and POST, every `sample_valid` writes `sample_in` to RAM[`wr_ptr`]. `wr_ptr` then increments modulo DEPTH, wrapping from DEPTH-1 to 0. The `prev` register captures the sample.
- FILL: counts samples. After the PRE_TRIG-th sample it moves to ARMED. No triggers are evaluated in FILL.
- ARMED: triggers on a valid sample S if any of these holds:
  - rising mode: `prev` < `trig_level` and S ≥ `trig_level`.
  - falling mode: `prev` ≥ `trig_level` and S < `trig_level`.
  - `force_trig` was seen since entering ARMED.
- Trigger sample: it is written normally and its address is stored as `trig_addr`. The state moves to POST with `post_cnt`=1.
- POST: each valid sample increments `post_cnt`. When `post_cnt` reaches DEPTH-PRE_TRIG, the state moves to DONE.
- DONE:
  - `sample_valid` is ignored.
  - The read pointer starts at (`trig_addr` - PRE_TRIG) mod DEPTH and increments mod DEPTH.
  - Exactly DEPTH words are streamed.
  - Word index PRE_TRIG is the trigger sample.
  - `rd_last` is high with the DEPTH-th word.
  - The handshake where `rd_valid` and `rd_last` are high together (with `rd_ready`) returns the state to IDLE.
- Comparisons are 12-bit unsigned. There is no hysteresis.
- Simultaneous events:
  - `arm` outside IDLE is ignored.
  - `force_trig` outside ARMED is ignored.
  - `arm` in the same cycle as the final readout handshake is ignored (the state is not yet IDLE).
- Reset mid-capture or mid-readout: returns to IDLE at once and drops the current window. RAM contents are don't-care.

## Timing
- Reset values: `busy`, `triggered`, `capture_done`, `rd_valid`, `rd_last` = 0; `rd_data` = 0; state is IDLE.
- `busy` rises the cycle after `arm` is accepted. The sample strobed in that same cycle is not captured.
- The state change on the completing sample is registered and visible the next cycle.
- RAM read latency is 1 cycle. `rd_valid` asserts no later than 2 cycles after entering DONE.
- Readout throughput: one word per clock while `rd_ready` is held high, via a prefetch/skid register.
- While `rd_valid`=1 and `rd_ready`=0, `rd_data` and `rd_last` are held stable and `rd_valid` does not drop.
- `rd_valid` deasserts the cycle after the last handshake.

## Structure
- Shared package `adc_pkg`: ADC_W=12, the state enum (IDLE/FILL/ARMED/POST/DONE), and the ADC mid-scale constant 12'd2048 (default `trig_level` used in testbenches).
- Sub-module `capture_ram`: simple dual-port, one write port and one registered read port, DEPTH×12, inferable as block RAM.
- FSM, pointers, edge detector and readout skid logic live in the top module.

## Test plan
Unless noted, the bench uses DEPTH_LOG2=4 (DEPTH=16) and PRE_TRIG=4.
- Rising trigger: level=1000, ramp 0,100,200,… one sample per 4 clocks → trigger on 1000. Readout is 600,700,800,900,1000,…,2100 (16 words), `rd_last` on 2100, then IDLE.
- Falling trigger: level=2048, samples 3000,2500,2100,2049,2047,… → trigger sample 2047 at index 4.
- `force_trig`: constant 500, level 4000, assert `force_trig` in ARMED → next sample is at index 4. A `force_trig` pulsed in FILL has no effect.
- Wrap and backpressure: 40 samples before trigger, `rd_ready` toggled 1,0,0,1,… → 16 words in chronological order, no duplicates or drops, data stable while stalled.
- Back-to-back `sample_valid` for 20 cycles with a trigger inside → all samples captured.
- `rst` asserted mid-POST → next cycle all outputs 0. A fresh `arm` then yields a correct capture.
